// File: rtl/regfile_wb_arbiter_if.sv
// Bundles the ALU/load writeback streams and register-file write port of regfile_wb_arbiter.
// WB_PENDING_CHECK_EN adds the pending-load lookup signals.
interface regfile_wb_arbiter_if #(
    parameter int unsigned N = 5,
    parameter int unsigned W = 32
);
    logic         alu_valid;
    logic [N-1:0] alu_rd;
    logic [W-1:0] alu_data;
    logic         mem_valid;
    logic         mem_ready;
    logic [N-1:0] mem_rd;
    logic [W-1:0] mem_data;
    logic         RegWrite;
    logic [N-1:0] write;
    logic [W-1:0] data;
    logic         fifo_full;
    logic         fifo_empty;
`ifdef WB_PENDING_CHECK_EN
    logic [N-1:0] pend_addr1;
    logic [N-1:0] pend_addr2;
    logic         pend_hit1;
    logic         pend_hit2;
`endif

`ifdef WB_PENDING_CHECK_EN
    modport master (
        output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data, pend_addr1, pend_addr2,
        input  mem_ready, RegWrite, write, data, fifo_full, fifo_empty, pend_hit1, pend_hit2
    );
    modport slave (
        input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data, pend_addr1, pend_addr2,
        output mem_ready, RegWrite, write, data, fifo_full, fifo_empty, pend_hit1, pend_hit2
    );
`else
    modport master (
        output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
        input  mem_ready, RegWrite, write, data, fifo_full, fifo_empty
    );
    modport slave (
        input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
        output mem_ready, RegWrite, write, data, fifo_full, fifo_empty
    );
`endif
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Merges ALU writebacks (priority) and buffered load returns onto one register-file write port.
// Optional macro WB_PENDING_CHECK_EN adds pend_addr/pend_hit lookups for decode stalls.
module regfile_wb_arbiter #(
    parameter int unsigned N     = 5,
    parameter int unsigned W     = 32,
    parameter int unsigned DEPTH = 4
) (
    input logic           clk,
    input logic           rst,
    regfile_wb_arbiter_if.slave bus
);
    localparam int unsigned Aw = $clog2(DEPTH);
    localparam logic [Aw:0] CountFull = (Aw + 1)'(DEPTH);

    logic [N-1:0]  fifo_rd_q   [DEPTH];
    logic [W-1:0]  fifo_data_q [DEPTH];
    logic [Aw-1:0] rd_ptr_q, rd_ptr_d;
    logic [Aw-1:0] wr_ptr_q, wr_ptr_d;
    logic [Aw:0]   count_q, count_d;

    logic          wr_en_q, wr_en_d;
    logic [N-1:0]  wr_addr_q, wr_addr_d;
    logic [W-1:0]  wr_data_q, wr_data_d;

    logic empty, full, mem_acc, alu_issue, pop, bypass, push;

    assign empty = (count_q == '0);
    assign full  = (count_q == CountFull);

    // x0 writes are consumed here and never reach the FIFO or the output register.
    assign mem_acc   = bus.mem_valid && !full;
    assign alu_issue = bus.alu_valid && (bus.alu_rd != '0);
    assign pop       = !alu_issue && !empty;
    assign bypass    = !alu_issue && empty && mem_acc && (bus.mem_rd != '0);
    assign push      = mem_acc && (bus.mem_rd != '0) && !bypass;

    always_comb begin
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (alu_issue) begin
            wr_en_d   = 1'b1;
            wr_addr_d = bus.alu_rd;
            wr_data_d = bus.alu_data;
        end else if (pop) begin
            wr_en_d   = 1'b1;
            wr_addr_d = fifo_rd_q[rd_ptr_q];
            wr_data_d = fifo_data_q[rd_ptr_q];
        end else if (bypass) begin
            wr_en_d   = 1'b1;
            wr_addr_d = bus.mem_rd;
            wr_data_d = bus.mem_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    // Storage needs no reset: validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            fifo_rd_q[wr_ptr_q]   <= bus.mem_rd;
            fifo_data_q[wr_ptr_q] <= bus.mem_data;
        end
    end

    assign bus.mem_ready  = !full;
    assign bus.RegWrite   = wr_en_q;
    assign bus.write      = wr_addr_q;
    assign bus.data       = wr_data_q;
    assign bus.fifo_full  = full;
    assign bus.fifo_empty = empty;

`ifdef WB_PENDING_CHECK_EN
    logic [DEPTH-1:0] entry_valid;
    logic [Aw-1:0]    offs;

    always_comb begin
        entry_valid = '0;
        offs        = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            // Slot i is live when its distance from the head is below the count.
            offs           = Aw'(i) - rd_ptr_q;
            entry_valid[i] = ({1'b0, offs} < count_q);
        end
    end

    always_comb begin
        bus.pend_hit1 = wr_en_q && (wr_addr_q == bus.pend_addr1);
        bus.pend_hit2 = wr_en_q && (wr_addr_q == bus.pend_addr2);
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (entry_valid[i] && fifo_rd_q[i] == bus.pend_addr1) bus.pend_hit1 = 1'b1;
            if (entry_valid[i] && fifo_rd_q[i] == bus.pend_addr2) bus.pend_hit2 = 1'b1;
        end
        if (bus.pend_addr1 == '0) bus.pend_hit1 = 1'b0;
        if (bus.pend_addr2 == '0) bus.pend_hit2 = 1'b0;
    end
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reset, bypass, priority, backpressure, x0, reset flush.
module tb_regfile_wb_arbiter;
    localparam int unsigned N = 5;
    localparam int unsigned W = 32;
    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    regfile_wb_arbiter_if #(.N(N), .W(W)) bus ();

    regfile_wb_arbiter #(.N(N), .W(W), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_alu(input logic v, input logic [N-1:0] rd, input logic [W-1:0] d);
        bus.alu_valid = v;
        bus.alu_rd    = rd;
        bus.alu_data  = d;
    endtask

    task automatic set_mem(input logic v, input logic [N-1:0] rd, input logic [W-1:0] d);
        bus.mem_valid = v;
        bus.mem_rd    = rd;
        bus.mem_data  = d;
    endtask

    initial begin
        set_alu(1'b0, '0, '0);
        set_mem(1'b0, '0, '0);
`ifdef WB_PENDING_CHECK_EN
        bus.pend_addr1 = '0;
        bus.pend_addr2 = '0;
`endif
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst_regwrite", 32'(bus.RegWrite), 32'd0);
        chk("rst_write", 32'(bus.write), 32'd0);
        chk("rst_data", bus.data, 32'd0);
        chk("rst_empty", 32'(bus.fifo_empty), 32'd1);
        chk("rst_full", 32'(bus.fifo_full), 32'd0);
        chk("rst_ready", 32'(bus.mem_ready), 32'd1);

        // Bypass straight to the output
        set_mem(1'b1, 5'd5, 32'hDEADBEEF);
        tick();
        set_mem(1'b0, '0, '0);
        chk("byp_regwrite", 32'(bus.RegWrite), 32'd1);
        chk("byp_write", 32'(bus.write), 32'd5);
        chk("byp_data", bus.data, 32'hDEADBEEF);
        chk("byp_empty", 32'(bus.fifo_empty), 32'd1);
        tick();
        chk("idle_regwrite", 32'(bus.RegWrite), 32'd0);
        chk("idle_hold_write", 32'(bus.write), 32'd5);
        chk("idle_hold_data", bus.data, 32'hDEADBEEF);

        // ALU wins, load queued then issued
        set_alu(1'b1, 5'd3, 32'h11);
        set_mem(1'b1, 5'd7, 32'h22);
        tick();
        set_alu(1'b0, '0, '0);
        set_mem(1'b0, '0, '0);
        chk("pri_alu_write", 32'(bus.write), 32'd3);
        chk("pri_alu_data", bus.data, 32'h11);
        chk("pri_queued", 32'(bus.fifo_empty), 32'd0);
        tick();
        chk("pri_mem_regwrite", 32'(bus.RegWrite), 32'd1);
        chk("pri_mem_write", 32'(bus.write), 32'd7);
        chk("pri_mem_data", bus.data, 32'h22);
        chk("pri_drained", 32'(bus.fifo_empty), 32'd1);
        tick();
        chk("pri_done", 32'(bus.RegWrite), 32'd0);

        // Fill under sustained ALU traffic, 5th load back-pressured
        set_alu(1'b1, 5'd1, 32'hA1);
        for (int k = 0; k < 4; k++) begin
            set_mem(1'b1, 5'(10 + k), 32'h100 + 32'(k));
            chk("fill_ready", 32'(bus.mem_ready), 32'd1);
            tick();
            chk("fill_alu_write", 32'(bus.write), 32'd1);
        end
        set_mem(1'b1, 5'd14, 32'h104);
        chk("full_flag", 32'(bus.fifo_full), 32'd1);
        chk("full_not_ready", 32'(bus.mem_ready), 32'd0);
        tick();
        chk("full_still", 32'(bus.fifo_full), 32'd1);
        set_alu(1'b0, '0, '0);
        tick();
        chk("pop0_write", 32'(bus.write), 32'd10);
        chk("pop0_data", bus.data, 32'h100);
        chk("pop0_ready", 32'(bus.mem_ready), 32'd1);
        tick();
        set_mem(1'b0, '0, '0);
        chk("pop1_write", 32'(bus.write), 32'd11);
        chk("pop1_full_again", 32'(bus.fifo_full), 32'd0);
        for (int k = 2; k < 5; k++) begin
            tick();
            chk("popk_regwrite", 32'(bus.RegWrite), 32'd1);
            chk("popk_write", 32'(bus.write), 32'(10 + k));
            chk("popk_data", bus.data, 32'h100 + 32'(k));
        end
        tick();
        chk("drain_regwrite", 32'(bus.RegWrite), 32'd0);
        chk("drain_empty", 32'(bus.fifo_empty), 32'd1);

        // x0 filter on both streams
        set_alu(1'b1, 5'd0, 32'hFFFFFFFF);
        set_mem(1'b1, 5'd0, 32'h33);
        tick();
        set_alu(1'b0, '0, '0);
        set_mem(1'b0, '0, '0);
        chk("x0_regwrite", 32'(bus.RegWrite), 32'd0);
        chk("x0_empty", 32'(bus.fifo_empty), 32'd1);
        chk("x0_hold_data", bus.data, 32'h104);

`ifdef WB_PENDING_CHECK_EN
        set_alu(1'b1, 5'd4, 32'h44);
        set_mem(1'b1, 5'd9, 32'h99);
        tick();
        set_alu(1'b0, '0, '0);
        set_mem(1'b0, '0, '0);
        bus.pend_addr1 = 5'd9;
        bus.pend_addr2 = 5'd0;
        #1;
        chk("pend_hit1_fifo", 32'(bus.pend_hit1), 32'd1);
        chk("pend_hit2_x0", 32'(bus.pend_hit2), 32'd0);
        bus.pend_addr2 = 5'd4;
        #1;
        chk("pend_hit2_outreg", 32'(bus.pend_hit2), 32'd1);
        tick();
        chk("pend_hit1_issuing", 32'(bus.pend_hit1), 32'd1);
        tick();
        chk("pend_hit1_clear", 32'(bus.pend_hit1), 32'd0);
        bus.pend_addr1 = '0;
        bus.pend_addr2 = '0;
`endif

        // Reset with two queued loads: none may ever issue
        set_alu(1'b1, 5'd2, 32'h55);
        set_mem(1'b1, 5'd20, 32'h200);
        tick();
        set_mem(1'b1, 5'd21, 32'h201);
        tick();
        set_alu(1'b0, '0, '0);
        set_mem(1'b0, '0, '0);
        chk("mid_queued", 32'(bus.fifo_empty), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_regwrite", 32'(bus.RegWrite), 32'd0);
        chk("mid_rst_empty", 32'(bus.fifo_empty), 32'd1);
        chk("mid_rst_write", 32'(bus.write), 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("mid_no_issue", 32'(bus.RegWrite), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
